instr_sequencer: RTL and testbench
==================================

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning PC load value on reset and on each accepted start.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port start, input, 1, a one-cycle request to run a program.
REQ-005 SHALL have port n_instr, input, 16, the number of instructions to execute; sampled only when start is accepted.
REQ-006 SHALL have port imem_req, output, 1, the instruction fetch request.
REQ-007 SHALL have port imem_addr, output, 32, the fetch address, equal to the current PC.
REQ-008 SHALL have port imem_ready, input, 1, the fetch data valid indication.
REQ-009 SHALL have port imem_rdata, input, 32, the fetched instruction word.
REQ-010 SHALL have port ir, output, 32, the instruction register fed to the decode logic.
REQ-011 SHALL have port op_b_imm, output, 1, selecting the immediate operand; high when ir[31:29] is 3'b110 or 3'b111.
REQ-012 SHALL have port alu_en, output, 1, the execute strobe.
REQ-013 SHALL have port rf_we, output, 1, the register-file write strobe.
REQ-014 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-015 SHALL have port done, output, 1, a one-cycle completion pulse.
REQ-016 SHALL have port retired, output, 16, the count of instructions completed in the current or most recent run.

Function
REQ-017 SHALL implement the states IDLE, FETCH, DECODE, EXECUTE and WRITEBACK.
REQ-018 IDLE: on start with n_instr != 0, SHALL load PC=RESET_PC, set remaining=n_instr, clear retired, and go to FETCH.
REQ-019 IDLE: on start with n_instr == 0, SHALL pulse done on the next cycle, issue no fetch, and remain in IDLE.
REQ-020 SHALL ignore start while busy is high.
REQ-021 FETCH: imem_req SHALL be high, with imem_addr held stable until imem_ready is sampled high.
REQ-022 FETCH: on the cycle imem_ready is high, ir SHALL load imem_rdata and the state SHALL go to DECODE; otherwise it SHALL stall in FETCH with no timeout.
REQ-023 DECODE: SHALL last exactly one cycle with all strobes low; ir and op_b_imm are stable from this cycle on.
REQ-024 EXECUTE: alu_en SHALL be high for exactly one cycle.
REQ-025 WRITEBACK: rf_we SHALL be high for exactly one cycle; PC SHALL advance by 4, retired SHALL increment, and remaining SHALL decrement.
REQ-026 WRITEBACK: if remaining was 1, the state SHALL go to IDLE with done high in the following IDLE cycle; otherwise it SHALL go to FETCH.
REQ-027 Minimum latency per instruction SHALL be 4 cycles when imem_ready is high on the first FETCH cycle.
REQ-028 PC SHALL wrap modulo 2^32 (32'hFFFF_FFFC + 4 = 0); retired SHALL wrap modulo 2^16.
REQ-029 imem_req, alu_en and rf_we SHALL be mutually exclusive in every cycle.
REQ-030 ir and retired SHALL hold their values in IDLE after a run.

Reset
REQ-031 When rst is high at an edge, the block SHALL enter IDLE, with PC=RESET_PC, ir=0, retired=0, remaining=0, and imem_req/alu_en/rf_we/busy/done=0 from the next cycle.
REQ-032 rst SHALL override start in the same cycle.
REQ-033 Reset during any state SHALL abort the run immediately; the aborted run produces no done pulse and no further strobe.

Structure
REQ-034 A shared package SHALL hold the state enum, ALUOP_IMM_A=3'b110, ALUOP_IMM_B=3'b111, PC_STEP=4, and the opcode field position [31:29].
REQ-035 SHALL be a single module with no sub-module; the FSM, PC, remaining and retired counters are inline.

Verification
REQ-036 start, n_instr=3, imem_ready tied high -> imem_addr 0,4,8; 12 busy cycles; done one cycle after the third rf_we; retired=3.
REQ-037 imem_ready low 5 cycles on the second fetch -> imem_req held with imem_addr=4 stable, no alu_en/rf_we during stall, ir loads the word on the ready cycle.
REQ-038 imem_rdata=32'hC000_0000 -> op_b_imm=1 from DECODE; 32'h2000_0000 -> op_b_imm=0.
REQ-039 start with n_instr=0 -> done next cycle, imem_req never asserted, busy stays 0.
REQ-040 rst asserted in EXECUTE of instruction 2 -> next cycle IDLE, retired=0, no rf_we, no done; a subsequent start restarts at RESET_PC.
REQ-041 RESET_PC=32'hFFFF_FFFC, n_instr=2 -> second fetch address 0; start pulsed mid-run -> ignored.

Source files
------------

// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: FSM state encoding,
// immediate-operand opcodes, PC step and opcode field position.
package instr_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_WRITEBACK
  } seq_state_e;

  localparam logic [2:0]  ALUOP_IMM_A = 3'b110;
  localparam logic [2:0]  ALUOP_IMM_B = 3'b111;
  localparam logic [31:0] PC_STEP     = 32'd4;
  localparam int          OPC_MSB     = 31;
  localparam int          OPC_LSB     = 29;

  function automatic logic is_imm_op(input logic [31:0] instr);
    logic [2:0] opc;
    opc = instr[OPC_MSB:OPC_LSB];
    return (opc == ALUOP_IMM_A) || (opc == ALUOP_IMM_B);
  endfunction

endpackage

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: fetches n_instr words starting at RESET_PC
// and steps each one through decode, execute and writeback with one-hot strobes.
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] n_instr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ir,
  output logic        op_b_imm,
  output logic        alu_en,
  output logic        rf_we,
  output logic        busy,
  output logic        done,
  output logic [15:0] retired
);

  seq_state_e  state;
  logic [31:0] pc;
  logic [15:0] remaining;

  assign imem_addr = pc;
  assign op_b_imm  = is_imm_op(ir);

  // Strobes are registered and set together with the state they belong to,
  // so each one is a clean flop output that is high only in its own state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      pc        <= RESET_PC;
      ir        <= '0;
      retired   <= '0;
      remaining <= '0;
      imem_req  <= 1'b0;
      alu_en    <= 1'b0;
      rf_we     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (n_instr != 16'd0) begin
              pc        <= RESET_PC;
              remaining <= n_instr;
              retired   <= '0;
              state     <= ST_FETCH;
              imem_req  <= 1'b1;
              busy      <= 1'b1;
            end else begin
              done <= 1'b1;
            end
          end
        end
        ST_FETCH: begin
          if (imem_ready) begin
            ir       <= imem_rdata;
            state    <= ST_DECODE;
            imem_req <= 1'b0;
          end
        end
        ST_DECODE: begin
          state  <= ST_EXECUTE;
          alu_en <= 1'b1;
        end
        ST_EXECUTE: begin
          state  <= ST_WRITEBACK;
          alu_en <= 1'b0;
          rf_we  <= 1'b1;
        end
        ST_WRITEBACK: begin
          rf_we     <= 1'b0;
          pc        <= pc + PC_STEP;
          retired   <= retired + 16'd1;
          remaining <= remaining - 16'd1;
          if (remaining == 16'd1) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state    <= ST_FETCH;
            imem_req <= 1'b1;
          end
        end
        default: begin
          state    <= ST_IDLE;
          imem_req <= 1'b0;
          alu_en   <= 1'b0;
          rf_we    <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: cycle table, directed corner
// sequences and randomized runs checked against a transaction-level model.
module tb_instr_sequencer;

  localparam logic [31:0] RPC_W = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        rst, start, imem_ready;
  logic [15:0] n_instr;
  logic [31:0] imem_rdata;

  logic        imem_req, op_b_imm, alu_en, rf_we, busy, done;
  logic [31:0] imem_addr, ir;
  logic [15:0] retired;

  logic        w_imem_req, w_op_b_imm, w_alu_en, w_rf_we, w_busy, w_done;
  logic [31:0] w_imem_addr, w_ir;
  logic [15:0] w_retired;

  int checks = 0;
  int failures = 0;

  instr_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .n_instr(n_instr),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .ir(ir), .op_b_imm(op_b_imm), .alu_en(alu_en),
    .rf_we(rf_we), .busy(busy), .done(done), .retired(retired)
  );

  instr_sequencer #(.RESET_PC(RPC_W)) dut_w (
    .clk(clk), .rst(rst), .start(start), .n_instr(n_instr),
    .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .ir(w_ir), .op_b_imm(w_op_b_imm), .alu_en(w_alu_en),
    .rf_we(w_rf_we), .busy(w_busy), .done(w_done), .retired(w_retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, start;
    logic [15:0] n;
    logic        rdy;
    logic [31:0] rdata;
    logic        req;
    logic [31:0] addr, ir;
    logic        imm, alu, we, busy, done;
    logic [15:0] ret;
  } vec_t;

  vec_t tbl [12];

  function automatic vec_t mk(input logic r, input logic s, input logic [15:0] n,
                              input logic rdy, input logic [31:0] rd,
                              input logic req, input logic [31:0] addr,
                              input logic [31:0] irv, input logic imm,
                              input logic alu, input logic we, input logic bsy,
                              input logic dn, input logic [15:0] ret);
    vec_t v;
    v.rst = r; v.start = s; v.n = n; v.rdy = rdy; v.rdata = rd;
    v.req = req; v.addr = addr; v.ir = irv; v.imm = imm; v.alu = alu;
    v.we = we; v.busy = bsy; v.done = dn; v.ret = ret;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run_to_done(input string nm);
    int k;
    k = 0;
    imem_ready = 1'b1;
    while (!done && k < 200) begin
      tick();
      k++;
    end
    chk({nm, ".done_reached"}, 32'(done), 32'd1);
  endtask

  int          n, fidx, stalls, busyc, aluc, wec, donec, k;
  logic [31:0] wexp;
  bit          pend;

  initial begin
    rst = 1'b1; start = 1'b0; n_instr = '0; imem_ready = 1'b0; imem_rdata = '0;
    tick(); tick();
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.req", 32'(imem_req), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.ir", ir, 32'd0);
    chk("rst.retired", 32'(retired), 32'd0);
    chk("rst.addr", imem_addr, 32'd0);
    chk("rst.addr_w", w_imem_addr, RPC_W);
    rst = 1'b0;

    // Two-instruction run with ready high, then a zero-length start.
    tbl[0]  = mk(0,1,16'd2,0,32'h0,          1,32'd0,32'h0,        0,0,0,1,0,16'd0);
    tbl[1]  = mk(0,0,16'd0,1,32'hC000_0000,  0,32'd0,32'hC000_0000,1,0,0,1,0,16'd0);
    tbl[2]  = mk(0,0,16'd0,1,32'hDEAD_BEEF,  0,32'd0,32'hC000_0000,1,1,0,1,0,16'd0);
    tbl[3]  = mk(0,0,16'd0,0,32'h0,          0,32'd0,32'hC000_0000,1,0,1,1,0,16'd0);
    tbl[4]  = mk(0,0,16'd0,0,32'h0,          1,32'd4,32'hC000_0000,1,0,0,1,0,16'd1);
    tbl[5]  = mk(0,0,16'd0,1,32'h2000_0000,  0,32'd4,32'h2000_0000,0,0,0,1,0,16'd1);
    tbl[6]  = mk(0,1,16'd7,0,32'h0,          0,32'd4,32'h2000_0000,0,1,0,1,0,16'd1);
    tbl[7]  = mk(0,0,16'd0,0,32'h0,          0,32'd4,32'h2000_0000,0,0,1,1,0,16'd1);
    tbl[8]  = mk(0,0,16'd0,0,32'h0,          0,32'd8,32'h2000_0000,0,0,0,0,1,16'd2);
    tbl[9]  = mk(0,0,16'd0,0,32'h0,          0,32'd8,32'h2000_0000,0,0,0,0,0,16'd2);
    tbl[10] = mk(0,1,16'd0,1,32'h0,          0,32'd8,32'h2000_0000,0,0,0,0,1,16'd2);
    tbl[11] = mk(0,0,16'd0,0,32'h0,          0,32'd8,32'h2000_0000,0,0,0,0,0,16'd2);

    for (int i = 0; i < 12; i++) begin
      rst = tbl[i].rst; start = tbl[i].start; n_instr = tbl[i].n;
      imem_ready = tbl[i].rdy; imem_rdata = tbl[i].rdata;
      tick();
      chk($sformatf("tbl%0d.req", i),     32'(imem_req), 32'(tbl[i].req));
      chk($sformatf("tbl%0d.addr", i),    imem_addr,     tbl[i].addr);
      chk($sformatf("tbl%0d.ir", i),      ir,            tbl[i].ir);
      chk($sformatf("tbl%0d.imm", i),     32'(op_b_imm), 32'(tbl[i].imm));
      chk($sformatf("tbl%0d.alu", i),     32'(alu_en),   32'(tbl[i].alu));
      chk($sformatf("tbl%0d.we", i),      32'(rf_we),    32'(tbl[i].we));
      chk($sformatf("tbl%0d.busy", i),    32'(busy),     32'(tbl[i].busy));
      chk($sformatf("tbl%0d.done", i),    32'(done),     32'(tbl[i].done));
      chk($sformatf("tbl%0d.retired", i), 32'(retired),  32'(tbl[i].ret));
    end
    start = 1'b0; imem_ready = 1'b0;

    // Five-cycle stall on the second fetch.
    start = 1'b1; n_instr = 16'd3; tick(); start = 1'b0;
    chk("stall.first_addr", imem_addr, 32'd0);
    imem_ready = 1'b1; imem_rdata = 32'hA000_0001; tick();
    imem_ready = 1'b0; tick(); tick(); tick();
    for (int s = 0; s < 5; s++) begin
      chk($sformatf("stall%0d.req", s),  32'(imem_req), 32'd1);
      chk($sformatf("stall%0d.addr", s), imem_addr,     32'd4);
      chk($sformatf("stall%0d.alu", s),  32'(alu_en),   32'd0);
      chk($sformatf("stall%0d.we", s),   32'(rf_we),    32'd0);
      chk($sformatf("stall%0d.ir", s),   ir,            32'hA000_0001);
      tick();
    end
    chk("stall.release_addr", imem_addr, 32'd4);
    imem_ready = 1'b1; imem_rdata = 32'hE000_0005; tick();
    chk("stall.ir_loaded", ir, 32'hE000_0005);
    chk("stall.imm", 32'(op_b_imm), 32'd1);
    chk("stall.req_low", 32'(imem_req), 32'd0);
    run_to_done("stall");
    chk("stall.retired", 32'(retired), 32'd3);

    // Reset in EXECUTE of the second instruction.
    start = 1'b1; n_instr = 16'd3; imem_ready = 1'b1; imem_rdata = 32'h1234_5678;
    tick(); start = 1'b0;
    for (int c = 0; c < 6; c++) tick();
    chk("abort.in_exec", 32'(alu_en), 32'd1);
    chk("abort.exec_addr", imem_addr, 32'd4);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("abort.busy", 32'(busy), 32'd0);
    chk("abort.retired", 32'(retired), 32'd0);
    chk("abort.ir", ir, 32'd0);
    chk("abort.addr", imem_addr, 32'd0);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("abort%0d.we", c),   32'(rf_we),    32'd0);
      chk($sformatf("abort%0d.done", c), 32'(done),     32'd0);
      chk($sformatf("abort%0d.req", c),  32'(imem_req), 32'd0);
      tick();
    end
    start = 1'b1; n_instr = 16'd1; tick(); start = 1'b0;
    chk("restart.addr", imem_addr, 32'd0);
    chk("restart.addr_w", w_imem_addr, RPC_W);
    run_to_done("restart");

    // PC wrap from 32'hFFFF_FFFC, with a start pulse mid-run.
    start = 1'b1; n_instr = 16'd2; imem_ready = 1'b1; tick(); start = 1'b0;
    chk("wrap.first_addr", w_imem_addr, RPC_W);
    start = 1'b1; n_instr = 16'd9; tick(); start = 1'b0;
    tick(); tick(); tick();
    chk("wrap.second_req", 32'(w_imem_req), 32'd1);
    chk("wrap.second_addr", w_imem_addr, 32'd0);
    run_to_done("wrap");
    chk("wrap.retired", 32'(w_retired), 32'd2);

    // Reset wins over a simultaneous start.
    tick();
    rst = 1'b1; start = 1'b1; n_instr = 16'd5; tick();
    rst = 1'b0; start = 1'b0;
    chk("rststart.busy", 32'(busy), 32'd0);
    tick();
    chk("rststart.busy2", 32'(busy), 32'd0);
    chk("rststart.req", 32'(imem_req), 32'd0);

    // Randomized runs against a transaction-level model.
    for (int r = 0; r < 12; r++) begin
      n = $urandom_range(1, 6);
      fidx = 0; stalls = 0; busyc = 0; aluc = 0; wec = 0; donec = 0; k = 0; pend = 0;
      wexp = '0;
      start = 1'b1; n_instr = 16'(n); imem_ready = 1'b0;
      while (donec == 0 && k < 300) begin
        tick();
        k++;
        start = 1'b0;
        if (pend) begin
          chk($sformatf("rnd%0d.ir", r), ir, wexp);
          chk($sformatf("rnd%0d.imm", r), 32'(op_b_imm), 32'(wexp[31:29] >= 3'd6));
          pend = 0;
        end
        chk($sformatf("rnd%0d.excl", r),
            32'((32'(imem_req) + 32'(alu_en) + 32'(rf_we)) <= 32'd1), 32'd1);
        chk($sformatf("rnd%0d.retired", r), 32'(retired), 32'(wec));
        if (busy) busyc++;
        if (alu_en) aluc++;
        if (done) donec++;
        if (imem_req) begin
          chk($sformatf("rnd%0d.addr", r), imem_addr, 32'(fidx * 4));
          chk($sformatf("rnd%0d.addr_w", r), w_imem_addr, RPC_W + 32'(fidx * 4));
          imem_ready = ($urandom_range(0, 2) != 0);
          imem_rdata = $urandom;
          if (imem_ready) begin
            wexp = imem_rdata;
            pend = 1;
            fidx++;
          end else begin
            stalls++;
          end
        end else begin
          imem_ready = 1'($urandom_range(0, 1));
          imem_rdata = $urandom;
        end
        if (busy && $urandom_range(0, 5) == 0) begin
          start = 1'b1;
          n_instr = 16'($urandom);
        end
        if (rf_we) wec++;
      end
      start = 1'b0; imem_ready = 1'b0;
      chk($sformatf("rnd%0d.done_once", r), 32'(donec), 32'd1);
      chk($sformatf("rnd%0d.busy_end", r), 32'(busy), 32'd0);
      chk($sformatf("rnd%0d.final_retired", r), 32'(retired), 32'(n));
      chk($sformatf("rnd%0d.alu_count", r), 32'(aluc), 32'(n));
      chk($sformatf("rnd%0d.we_count", r), 32'(wec), 32'(n));
      chk($sformatf("rnd%0d.fetches", r), 32'(fidx), 32'(n));
      chk($sformatf("rnd%0d.busy_cycles", r), 32'(busyc), 32'(4 * n + stalls));
      tick();
      chk($sformatf("rnd%0d.ret_hold", r), 32'(retired), 32'(n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
